// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_pkg;

  // Transfer-level FSM: waiting for a setup phase, or inside an access phase.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  // Largest supported wait-state count; the counter is sized to hold it.
  localparam int MAX_WAIT_STATES = 15;
  localparam int CNT_W           = $clog2(MAX_WAIT_STATES + 1);

  // Default content of the read-only identification register.
  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA9B0_0001;

endpackage

// File: rtl/apb_slave_regs_wait_ctr.sv
// Wait-state counter: counts stalled access cycles, flags when the terminal count is reached.
// Latency: done is combinational from the registered count; count updates one edge after enable.
// Backpressure: none; clear has priority over enable.
module apb_wait_ctr
  import apb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Count stalled access cycles; restart from zero at every new setup phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == terminal);

endmodule

// File: rtl/apb_slave_regs.sv
// APB register slave: NUM_REGS word registers, register 0 is a read-only ID. Optional
// byte-strobe writes when APB_SLAVE_REGS_PSTRB_EN is defined (default: full-word writes).
// Latency: PREADY after WAIT_STATES access cycles; backpressure via PREADY low, abort on PSEL drop.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int NUM_REGS       = 8,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int WAIT_STATES    = 2,
  parameter logic [APB_DATA_WIDTH-1:0] ID_VALUE = APB_DATA_WIDTH'(ID_VALUE_DEFAULT)
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        PSEL,
  input  logic [APB_ADDR_WIDTH-1:0]   PADDR,
  input  logic                        PWRITE,
  input  logic [APB_DATA_WIDTH-1:0]   PWDATA,
  input  logic                        PENABLE,
  input  logic [APB_DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]                  PPROT,
  output logic [APB_DATA_WIDTH-1:0]   PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = APB_DATA_WIDTH / 8;

  apb_state_t state_q, state_d;

  logic                      cnt_done;
  logic                      cnt_clear;
  logic                      cnt_enable;
  logic                      ready_int;
  logic [IDX_W-1:0]          idx;
  logic [APB_ADDR_WIDTH-1:0] addr_hi;
  logic                      addr_err;
  logic                      acc_err;
  logic                      wr_commit;
  logic [STRB_W-1:0]         byte_en;
  logic [APB_DATA_WIDTH-1:0] rd_word;
  logic [APB_DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

  // PPROT carries no meaning for this slave.
  logic unused_prot;
  assign unused_prot = ^{PPROT, PSTRB};

  // Address decode: word index, plus misalignment / out-of-range / ID-write errors.
  assign idx      = PADDR[IDX_W+1:2];
  assign addr_hi  = PADDR >> (IDX_W + 2);
  assign addr_err = (PADDR[1:0] != 2'b00) || (addr_hi != '0) || (int'(idx) >= NUM_REGS);
  assign acc_err  = addr_err || (PWRITE && (idx == '0));

  // Ready only in a properly set-up access phase once the wait count is reached;
  // reset masks it so nothing completes while PRESET is high.
  assign ready_int  = (state_q == ACCESS) && cnt_done && PSEL && PENABLE && !PRESET;
  assign cnt_clear  = (state_q == IDLE) && PSEL && !PENABLE;
  assign cnt_enable = (state_q == ACCESS) && PSEL && PENABLE && !ready_int;

  apb_wait_ctr u_wait_ctr (
    .clk      (PCLK),
    .rst      (PRESET),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (CNT_W'(WAIT_STATES)),
    .done     (cnt_done)
  );

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter ACCESS on a setup phase, leave on completion or when PSEL drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (PSEL && !PENABLE) state_d = ACCESS;
      ACCESS:  if (!PSEL || ready_int) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef APB_SLAVE_REGS_PSTRB_EN
  assign byte_en = PSTRB;
`else
  assign byte_en = '1;
`endif

  assign wr_commit = ready_int && PWRITE && !acc_err;

  // Register file: cleared by reset, updated only on the completing edge of a clean write.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (idx == IDX_W'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (byte_en[b]) regs[i][8*b +: 8] <= PWDATA[8*b +: 8];
          end
        end
      end
    end
  end

  // Read mux: index 0 is the fixed ID word.
  always_comb begin
    rd_word = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) rd_word = regs[i];
    end
  end

  assign PREADY  = ready_int;
  assign PSLVERR = ready_int && acc_err;
  assign PRDATA  = (ready_int && !PWRITE && !acc_err) ? rd_word : '0;

endmodule

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_REGS, 8, word registers implemented.
- APB_ADDR_WIDTH, 32, PADDR width.
- APB_DATA_WIDTH, 32, data width, multiple of 8.
- WAIT_STATES, 2, PREADY-low cycles per access phase, 0..15.
- ID_VALUE, 32'hA9B0_0001, read-only content of register 0.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- PCLK, in, 1, single clock; all state on rising edge.
- PRESET, in, 1, reset; synchronous, active-high.
- PSEL, in, 1, select.
- PADDR, in, APB_ADDR_WIDTH, byte address.
- PWRITE, in, 1, 1 = write.
- PWDATA, in, APB_DATA_WIDTH, write data.
- PENABLE, in, 1, access phase.
- PSTRB, in, APB_DATA_WIDTH/8, byte strobes.
- PPROT, in, 3, accepted and ignored.
- PRDATA, out, APB_DATA_WIDTH, read data.
- PREADY, out, 1, transfer completes.
- PSLVERR, out, 1, error, qualified by PREADY.

Function
REQ-003 FSM states SHALL be IDLE and ACCESS.
- IDLE->ACCESS on an edge where PSEL=1 and PENABLE=0 (setup phase).
- ACCESS->IDLE on the edge where PREADY=1, or on any edge where PSEL=0 (abort).
REQ-004 On IDLE->ACCESS, wait counter cnt SHALL load 0; each ACCESS cycle with PREADY=0 and PSEL=PENABLE=1 SHALL increment cnt.
REQ-005 PREADY SHALL be 1 only when state=ACCESS, cnt=WAIT_STATES, PSEL=PENABLE=1; one pulse per transfer. Access latency from the first PENABLE cycle SHALL be WAIT_STATES cycles (0 = ready in first access cycle).
REQ-006 Register index SHALL be PADDR[log2(NUM_REGS)+1:2].
- Error when PADDR[1:0]!=0, any PADDR bit above the index field is set, or a write targets register 0.
- PSLVERR=1 only in the PREADY cycle of an errored transfer.
REQ-007 Writes SHALL commit on the PREADY edge only, never on error or abort; register 0 SHALL always read ID_VALUE.
REQ-008 Reads SHALL drive PRDATA=register content during the PREADY cycle; PRDATA SHALL be 0 in all other cycles and on errored reads.
REQ-009 PSEL&PENABLE seen in IDLE (no setup) SHALL be ignored: stay IDLE, PREADY=0.
REQ-010 PADDR/PWRITE/PWDATA SHALL be sampled combinationally in the PREADY cycle; changes during wait states are a master violation and SHALL not be checked.
REQ-011 Back-to-back setup SHALL be accepted: PSEL=1, PENABLE=0 in the cycle after PREADY SHALL re-enter ACCESS.

Reset
REQ-012 While PRESET=1 at an edge, the block SHALL set state=IDLE, cnt=0, registers 1..NUM_REGS-1 to 0.
REQ-013 Outputs during and after reset SHALL be PREADY=0, PSLVERR=0, PRDATA=0.
REQ-014 Reset mid-transfer SHALL abort with no write; the transfer SHALL not complete.

Configuration
REQ-015 Macro APB_SLAVE_REGS_PSTRB_EN, when defined, SHALL make writes update only bytes whose PSTRB bit is 1; PSTRB=0 on a write SHALL complete without error and change nothing.
REQ-016 Without APB_SLAVE_REGS_PSTRB_EN, PSTRB SHALL be ignored and every write SHALL update the full word.

Structure
REQ-017 Package apb_pkg SHALL hold the state enum (IDLE, ACCESS), the maximum WAIT_STATES constant (15) and the default ID_VALUE.
REQ-018 The wait counter SHALL be sub-module apb_wait_ctr, with inputs clear and enable, a terminal value, and a done output; the remaining logic SHALL be in apb_slave_regs.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Write 0xAAAA_AAAA to 0x04 (WAIT_STATES=2): PREADY on the 3rd PENABLE cycle; a read of 0x04 then returns 0xAAAA_AAAA, PSLVERR=0.
- Read 0x00: PRDATA=0xA9B0_0001. Write 0x00: PSLVERR=1 with PREADY, a later read still returns the ID.
- Read 0x20 (NUM_REGS=8) and read 0x06: each gives PREADY with PSLVERR=1 and PRDATA=0.
- PSTRB_EN defined: write 0x1234_5678 to 0x08, then write 0xFFFF_FFFF with PSTRB=4'b0010; read gives 0x1234_FF78. Macro undefined: read gives 0xFFFF_FFFF.
- Drop PSEL after one wait cycle of a write to 0x0C: no PREADY, register unchanged. Assert PRESET mid-access: outputs 0 and FSM IDLE next edge.
- WAIT_STATES=0, back-to-back reads of 0x04 then 0x08: each PREADY in its first PENABLE cycle, no idle cycle required between them.
